pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Controls the fetch-stage program counter. Every cycle it arbitrates the PC
//  redirect sources: exception, interrupt, eret, branch/jump, hazard stall and
//  sequential PC+4. It drives the PC register's enable and next-PC value.
//  It flushes wrong-path fetches after exception and eret redirects, and holds
//  eret until EPC is stable. Sits between decode/CP0 hazard logic and the PC register.
// PARAMETERS
//  RESET_PC      32'h0000_3000  PC value presented while reset is high
//  EXC_VECTOR    32'h0000_4180  exception/interrupt handler entry
//  FLUSH_CYCLES  2              cycles flush is held after exc/eret redirect (1..7)
// PORTS
//  clk          in   1   system clock, all state on posedge
//  reset        in   1   synchronous, active-high
//  pc_cur       in   32  current PC register value
//  stall        in   1   decode hazard stall request
//  br_take      in   1   branch/jump taken (decode stage)
//  br_target    in   32  branch/jump target
//  exc_req      in   1   synchronous exception pulse from pipeline
//  int_req      in   1   interrupt request level from CP0 (already masked by SR)
//  md_busy      in   1   multi-cycle mult/div busy; interrupts deferred while high
//  eret_req     in   1   eret in decode
//  epc          in   32  EPC value from CP0
//  epc_busy     in   1   mtc0 EPC in flight; EPC not yet valid
//  pc_en        out  1   PC register write enable
//  npc          out  32  next PC value
//  flush        out  1   kill instruction currently in F/D
//  int_ack      out  1   one-cycle pulse when an interrupt is taken
//  exc_taken    out  1   one-cycle pulse on any exc/int redirect
// BEHAVIOUR
//  Interface: one clock `clk`; `reset` is synchronous and active-high.
//  - Reset values: pc_en=1, npc=RESET_PC, flush=0, int_ack=0, exc_taken=0,
//    state=RUN, flush counter=0, interrupt-pending latch=0.
//  - Outputs are combinational from the current state and inputs, giving zero-latency
//    redirect. Pulses and state update on posedge clk.
//  - Interrupt-pending latch (ipend): set by int_req. Cleared when the interrupt is
//    taken or int_req drops. An interrupt is eligible only when md_busy=0.
//  - Priority in RUN and STALL: exc_req > (ipend & !md_busy) > eret > stall > br_take > PC+4.
//  - States:
//    RUN:    pc_en=1, npc=pc_cur+4 (mod 2^32, wrap at 32'hFFFF_FFFC->0).
//            br_take gives npc=br_target. stall gives pc_en=0 and goes to STALL.
//            eret with epc_busy=0 gives npc=epc and goes to FLUSH.
//            eret with epc_busy=1 gives pc_en=0 and goes to ERET_WAIT.
//    STALL:  pc_en=0 while stall=1. br_take is ignored. On stall=0, same
//            decision as RUN that cycle.
//    ERET_WAIT: pc_en=0. On epc_busy=0: npc=epc, pc_en=1, go to FLUSH.
//            stall is ignored here.
//    FLUSH:  flush=1, pc_en=1, npc=pc_cur+4. Lasts FLUSH_CYCLES cycles, then RUN.
//            br_take, eret and stall are ignored (wrong-path).
//  - Exc/int redirect (any state): npc=EXC_VECTOR, pc_en=1, exc_taken=1.
//    int_ack=1 only if an interrupt caused it and exc_req=0. Goes to FLUSH with the
//    counter reloaded. A redirect inside FLUSH restarts the count.
//  - Simultaneous exc_req and interrupt: a single redirect, int_ack=0, ipend kept.
//  - Reset mid-operation (any state): next cycle is RUN with counters cleared.
//    No pulse is emitted.
// CONFIGURATION
//  PC_SEQ_PERF_EN defined: adds outputs stall_cnt[15:0] and flush_cnt[15:0].
//    stall_cnt counts cycles with pc_en=0 caused by STALL/ERET_WAIT; flush_cnt
//    counts FLUSH cycles. Both saturate at 16'hFFFF and clear on reset.
//  Undefined: no counter ports and no counter logic.
// TESTING
//  1. reset=1 2 cycles, pc_cur=32'h3000 -> npc=32'h3000, pc_en=1. Release ->
//     npc=32'h3004.
//  2. br_take=1, br_target=32'h3100 in RUN -> npc=32'h3100, same cycle. The same
//     request during stall=1 -> pc_en=0, branch ignored.
//  3. eret_req=1, epc_busy=1 for 3 cycles, epc=32'h3020 -> pc_en=0 for 3 cycles,
//     then npc=32'h3020, flush=1 for 2 cycles.
//  4. int_req=1 while md_busy=1 for 4 cycles -> no redirect. md_busy->0 ->
//     npc=32'h4180, int_ack=1 one cycle, flush 2 cycles.
//  5. exc_req and interrupt together -> npc=32'h4180, exc_taken=1, int_ack=0.
//     exc_req again in FLUSH -> flush extended 2 more cycles.
//  6. pc_cur=32'hFFFF_FFFC in RUN -> npc=0. reset asserted in ERET_WAIT ->
//     next cycle RUN, npc=RESET_PC.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC redirect arbiter.
// Picks the next PC from exception/interrupt, eret, branch, stall and PC+4.
// Outputs are combinational from state and inputs, so a redirect takes effect
// in the same cycle it is requested.
// Optional feature: define PC_SEQ_PERF_EN to add the stall_cnt/flush_cnt
// performance counters.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_4180,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_cur,
  input  logic        stall,
  input  logic        br_take,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        int_req,
  input  logic        md_busy,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic        epc_busy,
`ifdef PC_SEQ_PERF_EN
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
`endif
  output logic        pc_en,
  output logic [31:0] npc,
  output logic        flush,
  output logic        int_ack,
  output logic        exc_taken
);

  typedef enum logic [1:0] {RUN, STALL, ERET_WAIT, FLUSH} state_e;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [2:0]  fcnt_q, fcnt_d;
  logic        ipend_q, ipend_d;
  logic [31:0] pc_seq;
  logic        int_ok;

  assign pc_seq = pc_cur + 32'd4;  // wraps naturally at 2^32
  // An interrupt needs a latched request that is still asserted and no mult/div in flight.
  assign int_ok = ipend_q & int_req & ~md_busy;

  // Arbitrate redirect sources and compute outputs and next state.
  always_comb begin
    // NOTE: every signal gets a default here so no path can infer a latch.
    pc_en     = 1'b1;
    npc       = pc_seq;
    flush     = 1'b0;
    int_ack   = 1'b0;
    exc_taken = 1'b0;
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    ipend_d   = int_req;

    if (reset) begin
      npc     = RESET_PC;
      state_d = RUN;
      fcnt_d  = '0;
      ipend_d = 1'b0;
    end else if (exc_req || int_ok) begin
      // Exception wins over a simultaneous interrupt; the interrupt stays pending.
      npc       = EXC_VECTOR;
      exc_taken = 1'b1;
      int_ack   = int_ok & ~exc_req;
      flush     = (state_q == FLUSH);
      state_d   = FLUSH;
      fcnt_d    = FLUSH_LOAD;
      if (int_ok && !exc_req) ipend_d = 1'b0;
    end else begin
      unique case (state_q)
        RUN, STALL: begin
          if (eret_req) begin
            if (!epc_busy) begin
              npc     = epc;
              state_d = FLUSH;
              fcnt_d  = FLUSH_LOAD;
            end else begin
              pc_en   = 1'b0;
              npc     = pc_cur;
              state_d = ERET_WAIT;
            end
          end else if (stall) begin
            pc_en   = 1'b0;
            npc     = pc_cur;
            state_d = STALL;
          end else begin
            if (br_take) npc = br_target;
            state_d = RUN;
          end
        end
        ERET_WAIT: begin
          if (!epc_busy) begin
            npc     = epc;
            state_d = FLUSH;
            fcnt_d  = FLUSH_LOAD;
          end else begin
            pc_en = 1'b0;
            npc   = pc_cur;
          end
        end
        FLUSH: begin
          // Wrong-path instructions: ignore branch, eret and stall.
          flush = 1'b1;
          if (fcnt_q <= 3'd1) begin
            state_d = RUN;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q - 3'd1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Register sequencer state; reset is folded into the next-state logic above.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments to avoid ordering races.
    state_q <= state_d;
    fcnt_q  <= fcnt_d;
    ipend_q <= ipend_d;
  end

`ifdef PC_SEQ_PERF_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  // Saturating counters for stalled-PC cycles and flush cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_en && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (state_q == FLUSH && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
